matrix_result_reader: RTL and testbench

//   Unloads the 8x8 result matrix C from the dual-port result RAM after a GEMM run.

---
 rtl/matrix_result_reader.sv | 145 ++++++++++++++
 tb/tb_matrix_result_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_reader.sv
// rtl/matrix_result_reader.sv - streams the GEMM result RAM out as saturated valid/ready words
//
// Reads address pairs (2p, 2p+1) from the dual-port result RAM, saturates each
// DATA_W word to OUT_W, buffers them in a 4-entry FIFO and presents the FIFO
// head as a one-word-per-beat stream in ascending address order.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   start                 begin a readout (honoured in IDLE or DONE only)
//   rd_en                 read strobe shared by both RAM ports
//   rd_addr_1/rd_addr_2   even/odd address of the current pair
//   rd_data_1/rd_data_2   RAM data, one cycle after rd_en
//   out_data/out_valid    saturated word and its valid
//   out_ready             consumer accept
//   out_row_end/out_last  word closes a matrix row / closes the matrix
//   busy/done             FETCH or DRAIN / readout finished (level)
//   sat_seen              sticky: a word of this run was saturated
module matrix_result_reader #(
  parameter int DATA_W = 19,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int ROW_N  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_1,
  output logic [ADDR_W-1:0] rd_addr_2,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_row_end,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              sat_seen
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(SAT_MAX_I);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-SAT_MAX_I - 1);
  localparam logic [OUT_W-1:0]  OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ADDR_W-2:0] LAST_PAIR = (ADDR_W-1)'(DEPTH/2 - 1);
  localparam logic [ADDR_W-1:0] ROW_MOD   = ADDR_W'(ROW_N);
  localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(ROW_N - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-2:0] pair_ptr;
  logic              in_flight;
  logic [OUT_W-1:0]  fifo_mem [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        fifo_cnt;
  logic [ADDR_W-1:0] out_idx;
  logic              start_accept, can_issue, last_pair, pop;
  logic [OUT_W:0]    sat_1, sat_2;

  // Returns {saturated_flag, OUT_W-bit value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [DATA_W-1:0] x);
    if (x > SAT_MAX)      return {1'b1, OUT_MAX};
    else if (x < SAT_MIN) return {1'b1, OUT_MIN};
    else                  return {1'b0, x[OUT_W-1:0]};
  endfunction

  assign sat_1 = saturate($signed(rd_data_1));
  assign sat_2 = saturate($signed(rd_data_2));

  assign start_accept = start && (state == S_IDLE || state == S_DONE);
  // Issue only when the pair in flight plus the new pair are guaranteed a slot,
  // so a returning pair can always be pushed without overflow.
  assign can_issue    = (fifo_cnt + (in_flight ? 3'd2 : 3'd0)) <= 3'd2;
  assign last_pair    = (pair_ptr == LAST_PAIR);

  assign out_valid   = (fifo_cnt != 3'd0);
  assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_row_end = out_valid && ((out_idx % ROW_MOD) == ROW_LAST);
  assign out_last    = out_valid && (out_idx == IDX_LAST);
  assign pop         = out_valid && out_ready;
  assign rd_addr_1   = {pair_ptr, 1'b0};
  assign rd_addr_2   = {pair_ptr, 1'b1};
  assign busy        = (state == S_FETCH) || (state == S_DRAIN);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (can_issue) begin
          rd_en = 1'b1;
          if (last_pair) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (pop && out_last) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_ptr  <= '0;
      in_flight <= 1'b0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      fifo_cnt  <= 3'd0;
      out_idx   <= '0;
      sat_seen  <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      in_flight <= rd_en;
      if (start_accept) begin
        pair_ptr <= '0;
        sat_seen <= 1'b0;
      end else begin
        if (rd_en && !last_pair) pair_ptr <= pair_ptr + 1'b1;
        if (in_flight && (sat_1[OUT_W] || sat_2[OUT_W])) sat_seen <= 1'b1;
      end
      // Both words of a returning pair enter the FIFO in the same cycle.
      if (in_flight) begin
        fifo_mem[wr_ptr]        <= sat_1[OUT_W-1:0];
        fifo_mem[wr_ptr + 2'd1] <= sat_2[OUT_W-1:0];
        wr_ptr                  <= wr_ptr + 2'd2;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (start_accept)  out_idx <= '0;
      else if (pop)      out_idx <= out_idx + 1'b1;
      fifo_cnt <= fifo_cnt + (in_flight ? 3'd2 : 3'd0) - (pop ? 3'd1 : 3'd0);
    end
  end

endmodule

// File: tb/tb_matrix_result_reader.sv
// tb/tb_matrix_result_reader.sv - self-checking bench for matrix_result_reader
module tb_matrix_result_reader;
  localparam int DATA_W = 19;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int ROW_N  = 8;
  localparam int BUDGET = 1500;

  logic              clk = 1'b0;
  logic              reset, start, rd_en, out_valid, out_ready;
  logic              out_row_end, out_last, busy, done, sat_seen;
  logic [ADDR_W-1:0] rd_addr_1, rd_addr_2;
  logic [DATA_W-1:0] rd_data_1 = '0;
  logic [DATA_W-1:0] rd_data_2 = '0;
  logic [OUT_W-1:0]  out_data;

  matrix_result_reader #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
                         .DEPTH(DEPTH), .ROW_N(ROW_N)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_end(out_row_end), .out_last(out_last),
    .busy(busy), .done(done), .sat_seen(sat_seen)
  );

  always #5 clk = ~clk;

  // Dual-port RAM model with one cycle read latency.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_1 <= ram[rd_addr_1];
      rd_data_2 <= ram[rd_addr_2];
    end
  end

  typedef struct {
    int idx;
    int ram_val;
    int exp_out;
  } vec_t;
  vec_t vecs[8];

  int n_pass = 0;
  int n_total = 0;
  int exp_val [DEPTH];
  bit exp_sat;
  int got_data [DEPTH];
  bit got_row [DEPTH];
  bit got_last [DEPTH];
  int n_got;
  int hold_rden;
  int hold_err;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic setup_ram(input bit use_table);
    exp_sat = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DATA_W'(i);
      exp_val[i] = i;
    end
    if (use_table) begin
      for (int k = 0; k < 8; k++) begin
        ram[vecs[k].idx]     = DATA_W'(vecs[k].ram_val);
        exp_val[vecs[k].idx] = vecs[k].exp_out;
        if (vecs[k].ram_val != vecs[k].exp_out) exp_sat = 1'b1;
      end
    end
  endtask

  // One full readout: pct = out_ready duty in percent, hold = cycles of
  // out_ready=0 right after start, mid_at = pulse start again once this many
  // words have been accepted (-1: never).
  task automatic run(input string tag, input int pct, input int hold, input int mid_at);
    int cyc, rden, addr_err, stab_err, bd_err, data_err, row_err, last_err;
    bit prev_stall, mid_fired, fin, prev_row, prev_last;
    int prev_data, d;
    cyc = 0; rden = 0; addr_err = 0; stab_err = 0; bd_err = 0;
    data_err = 0; row_err = 0; last_err = 0;
    prev_stall = 0; mid_fired = 0; fin = 0; prev_data = 0; prev_row = 0; prev_last = 0;
    n_got = 0; hold_rden = 0; hold_err = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = (hold > 0) ? 1'b0 : 1'b1;
    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (mid_at >= 0 && !mid_fired && n_got == mid_at) begin
        start = 1'b1;
        mid_fired = 1'b1;
      end
      if (cyc <= hold)      out_ready = 1'b0;
      else if (pct >= 100)  out_ready = 1'b1;
      else                  out_ready = ($urandom_range(99) < pct);
      #1;
      d = int'($signed(out_data));
      if (cyc == 1) begin
        check({tag, " rd_en at +1"}, int'(rd_en), 1);
        check({tag, " busy at +1"}, int'(busy), 1);
        check({tag, " done cleared"}, int'(done), 0);
        check({tag, " sat_seen cleared"}, int'(sat_seen), 0);
      end
      if (cyc == 2) check({tag, " no valid at +2"}, int'(out_valid), 0);
      if (cyc == 3) check({tag, " valid at +3"}, int'(out_valid), 1);
      if (rd_en) begin
        if (rd_addr_1 != ADDR_W'(2 * rden) || rd_addr_2 != ADDR_W'(2 * rden + 1)) addr_err++;
        rden++;
        if (cyc <= hold) hold_rden++;
      end
      if (busy && done) bd_err++;
      if (cyc <= hold && cyc >= 3 && (!out_valid || d != exp_val[0])) hold_err++;
      if (prev_stall && (!out_valid || d != prev_data || out_row_end != prev_row ||
                         out_last != prev_last)) stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_data = d; prev_row = out_row_end; prev_last = out_last;
      if (out_valid && out_ready) begin
        if (n_got < DEPTH) begin
          got_data[n_got] = d;
          got_row[n_got]  = out_row_end;
          got_last[n_got] = out_last;
        end
        n_got++;
      end
      fin = done;
    end
    check({tag, " done reached"}, int'(done), 1);
    check({tag, " word count"}, n_got, DEPTH);
    for (int j = 0; j < DEPTH && j < n_got; j++) begin
      if (got_data[j] != exp_val[j]) data_err++;
      if (got_row[j] != ((j % ROW_N) == ROW_N - 1)) row_err++;
      if (got_last[j] != (j == DEPTH - 1)) last_err++;
    end
    check({tag, " data order errors"}, data_err, 0);
    check({tag, " row_end errors"}, row_err, 0);
    check({tag, " last errors"}, last_err, 0);
    check({tag, " stall stability errors"}, stab_err, 0);
    check({tag, " address errors"}, addr_err, 0);
    check({tag, " rd_en pulses"}, rden, DEPTH / 2);
    check({tag, " busy&done overlap"}, bd_err, 0);
    check({tag, " sat_seen"}, int'(sat_seen), int'(exp_sat));
    check({tag, " busy low in done"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    #1;
    check({tag, " done holds"}, int'(done), 1);
    check({tag, " valid low in done"}, int'(out_valid), 0);
  endtask

  initial begin
    int cnt, k;
    vecs[0] = '{5,  131071,  32767};
    vecs[1] = '{6,  -40000, -32768};
    vecs[2] = '{10,  32767,  32767};
    vecs[3] = '{11,  32768,  32767};
    vecs[4] = '{12, -32768, -32768};
    vecs[5] = '{13, -32769, -32768};
    vecs[6] = '{20,     -1,     -1};
    vecs[7] = '{21, -262144, -32768};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    setup_ram(1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", int'({rd_en, out_valid, out_row_end, out_last, busy, done, sat_seen}), 0);
    check("reset out_data", int'(out_data), 0);
    reset = 1'b0;

    // T1: linear ramp, full throughput
    run("T1", 100, 0, -1);

    // T2: saturation vectors
    setup_ram(1'b1);
    run("T2", 100, 0, -1);
    for (int i = 0; i < 8; i++)
      check($sformatf("T2 vec word%0d", vecs[i].idx), got_data[vecs[i].idx], vecs[i].exp_out);

    // T6: start in DRAIN and in FETCH ignored; start in DONE reruns
    run("T6a", 100, 0, 63);
    run("T6b", 100, 0, 10);

    // T3: random backpressure
    setup_ram(1'b0);
    run("T3", 30, 0, -1);

    // T4: consumer stalled right after start
    run("T4", 100, 20, -1);
    check("T4 rd_en during stall <= 2", int'(hold_rden <= 2), 1);
    check("T4 word0 held", hold_err, 0);

    // T5: reset in the middle of a run, then a clean rerun
    setup_ram(1'b1);
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 30 && k < 500) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_ready) cnt++;
      k++;
    end
    check("T5 reached word 30", cnt, 30);
    check("T5 sat_seen before reset", int'(sat_seen), 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("T5 outputs after reset", int'({rd_en, out_valid, out_row_end, out_last, busy, done, sat_seen}), 0);
    check("T5 out_data after reset", int'(out_data), 0);
    reset = 1'b0;
    run("T5", 100, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
